// File: rtl/mrd_pkg.sv
// Shared types and constants for the matrix result display.
// State encoding, segment patterns and result-set geometry.
package mrd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_E     = 7'b1111001;

  localparam int RES_W   = 4;
  localparam int NUM_RES = 4;

  // Entry 0 is r11 in the most significant nibble.
  function automatic logic [RES_W-1:0] res_entry(input logic [RES_W*NUM_RES-1:0] data,
                                                 input logic [1:0]               idx);
    return data[(NUM_RES - 1 - int'(idx)) * RES_W +: RES_W];
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit hex to 7-segment {g,f,e,d,c,b,a} active-high lookup.
// Zero latency, no flow control.
module seg7_hex_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/matrix_result_display.sv
// Shows a captured 2x2 result set one entry at a time (or 'E') on a single digit.
// First digit one cycle after handshake, HOLD_CYCLES per entry; res_ready low while busy.
// MRD_REPEAT_EN: cycle the display forever and accept a new set in any state.
module matrix_result_display
  import mrd_pkg::*;
#(
  parameter int HOLD_CYCLES = 10_000_000,
  parameter int CNT_W       = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  input  logic        err_in,
  output logic        res_ready,
  output logic [6:0]  seg_out,
  output logic [1:0]  idx_out,
  output logic        busy
);

`ifdef MRD_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [RES_W*NUM_RES-1:0] res_buf;

  logic       xfer;
  logic       hold_done;
  logic [1:0] idx_next;
  logic [3:0] dec_in;
  logic [6:0] dec_seg;

  assign res_ready = REPEAT || (state == IDLE);
  assign busy      = (state != IDLE);
  assign xfer      = res_valid && res_ready;
  assign hold_done = (cnt == HOLD_LAST);
  assign idx_next  = idx_out + 2'd1;

  // A fresh set decodes straight from the input bus so r11 shows on the next cycle.
  assign dec_in = xfer ? res_entry(res_data, 2'd0) : res_entry(res_buf, idx_next);

  seg7_hex_decoder u_dec (
    .hex (dec_in),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      res_buf <= '0;
      seg_out <= SEG_BLANK;
      idx_out <= 2'd0;
    end else if (xfer) begin
      res_buf <= res_data;
      cnt     <= '0;
      idx_out <= 2'd0;
      if (err_in) begin
        state   <= ERR;
        seg_out <= SEG_E;
      end else begin
        state   <= SHOW;
        seg_out <= dec_seg;
      end
    end else begin
      case (state)
        SHOW: begin
          if (hold_done) begin
            cnt <= '0;
            if (idx_out == 2'd3 && !REPEAT) begin
              state   <= IDLE;
              seg_out <= SEG_BLANK;
              idx_out <= 2'd0;
            end else begin
              idx_out <= idx_next;
              seg_out <= dec_seg;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ERR: begin
          if (hold_done) begin
            cnt <= '0;
            if (!REPEAT) begin
              state   <= IDLE;
              seg_out <= SEG_BLANK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
